// File: rtl/aa_ss_req_assembler.sv
// Turns tuser-coded AXI-Stream beats into single-cycle typed request records
// (two-beat write, one-beat read, read-return), dropping and counting malformed beats.
module aa_ss_req_assembler #(
  parameter int ADDR_W = 15,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [31:0]       s_tdata,
  input  logic [3:0]        s_tstrb,
  input  logic [1:0]        s_tuser,
  input  logic              s_tlast,
  output logic              req_vld,
  input  logic              req_rdy,
  output logic [1:0]        req_typ,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_data,
  output logic [3:0]        req_strb,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic {
    IDLE,
    WR_DATA
  } state_t;

  localparam logic [1:0] TU_WR = 2'b01;
  localparam logic [1:0] TU_RD = 2'b10;
  localparam logic [1:0] TU_RR = 2'b11;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_hold_q;

  logic              needs_slot;
  logic              accept;
  logic              complete;
  logic              drop;
  logic              capture_addr;
  logic [1:0]        rec_typ;
  logic [ADDR_W-1:0] rec_addr;
  logic [31:0]       rec_data;
  logic [3:0]        rec_strb;

  // A WR_DATA beat always waits for the output slot, even if it turns out malformed;
  // kept outside the decode block so ready never depends on its own acceptance.
  assign needs_slot = (state_q == WR_DATA) | (s_tuser[1] & s_tlast);
  assign s_tready   = rst_n & (clear | ~needs_slot | ~req_vld | req_rdy);
  assign accept     = s_tvalid & s_tready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    complete     = 1'b0;
    drop         = 1'b0;
    capture_addr = 1'b0;
    rec_typ      = '0;
    rec_addr     = '0;
    rec_data     = '0;
    rec_strb     = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_tuser == TU_WR && !s_tlast) begin
            capture_addr = 1'b1;
            state_d      = WR_DATA;
          end else if (s_tuser == TU_RD && s_tlast) begin
            complete = 1'b1;
            rec_typ  = TU_RD;
            rec_addr = s_tdata[ADDR_W-1:0];
            rec_strb = 4'hF;
          end else if (s_tuser == TU_RR && s_tlast) begin
            complete = 1'b1;
            rec_typ  = TU_RR;
            rec_data = s_tdata;
            rec_strb = 4'hF;
          end else begin
            drop = 1'b1;
          end
        end
      end

      WR_DATA: begin
        if (accept) begin
          state_d = IDLE;
          if (s_tuser == TU_WR && s_tlast) begin
            complete = 1'b1;
            rec_typ  = TU_WR;
            rec_addr = addr_hold_q;
            rec_data = s_tdata;
            rec_strb = s_tstrb;
          end else begin
            drop = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The beat presented during clear is swallowed without effect.
    if (clear) begin
      state_d      = IDLE;
      complete     = 1'b0;
      drop         = 1'b0;
      capture_addr = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the holding register is reset too; it is a single flop bank, not a memory array.
    if (!rst_n) begin
      addr_hold_q <= '0;
    end else if (capture_addr) begin
      addr_hold_q <= s_tdata[ADDR_W-1:0];
    end
  end

  // Load wins over retire, so a simultaneous handshake and completion keeps req_vld high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld  <= 1'b0;
      req_typ  <= '0;
      req_addr <= '0;
      req_data <= '0;
      req_strb <= '0;
    end else if (clear) begin
      req_vld  <= 1'b0;
    end else if (complete) begin
      req_vld  <= 1'b1;
      req_typ  <= rec_typ;
      req_addr <= rec_addr;
      req_data <= rec_data;
      req_strb <= rec_strb;
    end else if (req_vld && req_rdy) begin
      req_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clear) begin
      err_cnt <= '0;
    end else if (drop && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aa_ss_req_assembler.sv
// Directed bench for aa_ss_req_assembler: transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_aa_ss_req_assembler;

  localparam int ADDR_W = 15;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [31:0]       s_tdata = '0;
  logic [3:0]        s_tstrb = '0;
  logic [1:0]        s_tuser = '0;
  logic              s_tlast = 1'b0;
  logic              req_vld;
  logic              req_rdy = 1'b1;
  logic [1:0]        req_typ;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [3:0]        req_strb;
  logic [ERR_W-1:0]  err_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  aa_ss_req_assembler #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_typ(req_typ),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [1:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
  } rec_t;

  bit                m_mid_write;
  logic [ADDR_W-1:0] m_wr_addr;
  bit                m_have_rec;
  rec_t              m_rec;
  int                m_errors;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                at;
  } log_t;
  log_t retired[$];

  always @(negedge clk) begin
    bit   wants_slot, exp_ready, taken;
    rec_t r;
    cyc++;
    if (!rst_n) begin
      m_mid_write = 0;
      m_have_rec  = 0;
      m_errors    = 0;
      check("rst tready", s_tready, 0);
      check("rst vld", req_vld, 0);
      check("rst err", err_cnt, 0);
    end else begin
      wants_slot = m_mid_write || (s_tuser[1] && s_tlast);
      exp_ready  = clear || !wants_slot || !m_have_rec || req_rdy;
      check("tready", s_tready, exp_ready);
      check("vld", req_vld, m_have_rec);
      check("err", err_cnt, m_errors);
      if (m_have_rec) begin
        check("typ", req_typ, m_rec.typ);
        check("addr", req_addr, m_rec.addr);
        check("data", req_data, m_rec.data);
        check("strb", req_strb, m_rec.strb);
        if (req_rdy) retired.push_back('{addr: req_addr, at: cyc});
      end

      taken = s_tvalid && exp_ready;
      if (clear) begin
        m_mid_write = 0;
        m_have_rec  = 0;
        m_errors    = 0;
      end else begin
        if (m_have_rec && req_rdy) m_have_rec = 0;
        if (taken) begin
          r = '{typ: 2'b00, addr: '0, data: '0, strb: 4'hF};
          if (m_mid_write) begin
            m_mid_write = 0;
            if (s_tuser == 2'b01 && s_tlast) begin
              r = '{typ: 2'b01, addr: m_wr_addr, data: s_tdata, strb: s_tstrb};
              m_rec = r; m_have_rec = 1;
            end else begin
              m_errors = (m_errors < 255) ? m_errors + 1 : 255;
            end
          end else if (s_tuser == 2'b01 && !s_tlast) begin
            m_mid_write = 1;
            m_wr_addr   = s_tdata[ADDR_W-1:0];
          end else if (s_tuser == 2'b10 && s_tlast) begin
            r.typ = 2'b10; r.addr = s_tdata[ADDR_W-1:0];
            m_rec = r; m_have_rec = 1;
          end else if (s_tuser == 2'b11 && s_tlast) begin
            r.typ = 2'b11; r.data = s_tdata;
            m_rec = r; m_have_rec = 1;
          end else begin
            m_errors = (m_errors < 255) ? m_errors + 1 : 255;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic present(input logic [1:0] u, input logic [31:0] d, input logic [3:0] st,
                         input logic l);
    s_tvalid = 1'b1; s_tuser = u; s_tdata = d; s_tstrb = st; s_tlast = l;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    @(negedge clk);
    while (!s_tready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({name, " accepted"}, s_tready, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send(input logic [1:0] u, input logic [31:0] d, input logic [3:0] st,
                      input logic l, input string name);
    present(u, d, st, l);
    wait_accept(name);
  endtask

  task automatic realign;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset typ", req_typ, 0);
    check("reset addr", req_addr, 0);
    check("reset data", req_data, 0);
    check("reset strb", req_strb, 0);
    check("reset tready", s_tready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    realign;

    // Two-beat write
    send(2'b01, 32'h0000_3004, 4'hF, 1'b0, "wr beat0");
    send(2'b01, 32'hDEAD_BEEF, 4'h3, 1'b1, "wr beat1");
    @(negedge clk);
    check("wr vld", req_vld, 1);
    check("wr typ", req_typ, 2'b01);
    check("wr addr", req_addr, 15'h3004);
    check("wr data", req_data, 32'hDEAD_BEEF);
    check("wr strb", req_strb, 4'h3);
    realign;

    // Back-to-back reads, no bubbles
    retired.delete();
    begin
      logic [31:0] addrs [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
      for (int i = 0; i < 4; i++) send(2'b10, addrs[i], 4'h0, 1'b1, "rd b2b");
      repeat (2) realign;
      check("b2b count", retired.size(), 4);
      for (int i = 0; i < 4 && i < retired.size(); i++) begin
        check("b2b order", retired[i].addr, addrs[i][ADDR_W-1:0]);
        if (i > 0) check("b2b no bubble", retired[i].at - retired[i-1].at, 1);
      end
    end

    // Backpressure: record 0x10 held while req_rdy is low
    req_rdy = 1'b0;
    send(2'b10, 32'h10, 4'h0, 1'b1, "rd hold0");
    present(2'b10, 32'h14, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold tready", s_tready, 0);
      check("hold addr", req_addr, 15'h10);
      check("hold vld", req_vld, 1);
    end
    realign;
    req_rdy = 1'b1;
    wait_accept("rd hold1");
    @(negedge clk);
    check("hold next addr", req_addr, 15'h14);
    realign;

    // Read-return
    send(2'b11, 32'h1234_5678, 4'h0, 1'b1, "rr");
    @(negedge clk);
    check("rr typ", req_typ, 2'b11);
    check("rr data", req_data, 32'h1234_5678);
    check("rr addr", req_addr, 0);
    check("rr strb", req_strb, 4'hF);
    realign;

    // Malformed: write address then read
    send(2'b01, 32'h100, 4'hF, 1'b0, "bad wr0");
    send(2'b10, 32'h20, 4'h0, 1'b1, "bad rd");
    @(negedge clk);
    check("bad no rec", req_vld, 0);
    check("bad err1", err_cnt, 1);
    realign;
    send(2'b10, 32'h24, 4'h0, 1'b1, "rd after bad");
    @(negedge clk);
    check("rd after bad vld", req_vld, 1);
    check("rd after bad typ", req_typ, 2'b10);
    check("rd after bad addr", req_addr, 15'h24);
    realign;
    send(2'b00, 32'h0, 4'h0, 1'b0, "tuser00");
    @(negedge clk);
    check("bad err2", err_cnt, 2);
    realign;

    // Clear mid-write, with a stalled record pending
    req_rdy = 1'b0;
    send(2'b10, 32'h30, 4'h0, 1'b1, "rd pend");
    send(2'b01, 32'h200, 4'hF, 1'b0, "clr wr0");
    present(2'b01, 32'hCAFE_0000, 4'hF, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    check("clr tready", s_tready, 1);
    realign;
    clear = 1'b0; s_tvalid = 1'b0; req_rdy = 1'b1;
    @(negedge clk);
    check("clr no rec", req_vld, 0);
    check("clr err", err_cnt, 0);
    realign;
    send(2'b10, 32'h44, 4'h0, 1'b1, "rd after clr");
    @(negedge clk);
    check("clr rd typ", req_typ, 2'b10);
    check("clr rd addr", req_addr, 15'h44);
    realign;

    // Saturation
    for (int i = 0; i < 300; i++) send(2'b00, i, 4'h0, 1'b0, "sat");
    @(negedge clk);
    check("sat 255", err_cnt, 255);
    repeat (3) realign;
    @(negedge clk);
    check("sat stays", err_cnt, 255);
    realign;

    // Reset mid-write loses the partial write
    send(2'b01, 32'h300, 4'hF, 1'b0, "rst wr0");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst tready", s_tready, 0);
    realign;
    rst_n = 1'b1;
    send(2'b01, 32'h5555_AAAA, 4'hF, 1'b1, "orphan wr1");
    @(negedge clk);
    check("midrst no rec", req_vld, 0);
    check("midrst err", err_cnt, 1);
    realign;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aa_ss_req_assembler.md
# aa_ss_req_assembler

Assembles AXI-Stream beats from the axis-slave receive path into complete, typed request records for the AA control logic. It sits between the axis-slave FIFO output and the control-logic SS request input. It converts the tuser-coded beat protocol into single-cycle request records:

- 01: two-beat write
- 10: one-beat read
- 11: read-return data

It also drops malformed sequences and counts them.

## Interface

Parameters:
- ADDR_W, 15: width of the request address taken from `tdata[ADDR_W-1:0]`.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of the partial write, the output record and the error counter
- s_tvalid  in  1  beat valid
- s_tready  out  1  beat accepted
- s_tdata  in  32  beat data
- s_tstrb  in  4  beat byte strobe
- s_tuser  in  2  beat type: 00 invalid, 01 write, 10 read, 11 read-return
- s_tlast  in  1  last beat of the transaction
- req_vld  out  1  request record valid
- req_rdy  in  1  control logic accepts the record
- req_typ  out  2  01 write, 10 read, 11 read-return
- req_addr  out  ADDR_W  address (writes and reads only; 0 for read-return)
- req_data  out  32  write data or read-return data (0 for reads)
- req_strb  out  4  write strobe (4'hF for read and read-return)
- err_cnt  out  ERR_W  number of dropped malformed beats, saturating

## Operation

- FSM states: IDLE and WR_DATA. A beat is accepted when `s_tvalid & s_tready`.
- The output is a one-entry record register.
  - It loads when a completing beat is accepted.
  - It clears `req_vld` when `req_rdy & req_vld` and no new completion occurs in the same cycle.
- Beats accepted in IDLE:
  - tuser 01, tlast=0: capture `tdata[ADDR_W-1:0]` into the address holding register, go to WR_DATA. No output slot is needed.
  - tuser 10, tlast=1: complete a read. `req_addr` = `tdata[ADDR_W-1:0]`.
  - tuser 11, tlast=1: complete a read-return. `req_data` = `tdata`.
  - Anything else (tuser 00, tuser 01 with tlast=1, tuser 10/11 with tlast=0): drop the beat, increment err_cnt.
- Beats accepted in WR_DATA:
  - tuser 01, tlast=1: complete a write. `req_addr` = holding register, `req_data` = `tdata`, `req_strb` = `tstrb`. Return to IDLE.
  - Otherwise: drop the beat and the partial write, increment err_cnt, return to IDLE. The dropped beat is not re-interpreted.
- s_tready (combinational):
  - 0 while `rst_n` is low.
  - 1 for beats that do not complete a record (write address beat, dropped beats).
  - `~req_vld | req_rdy` for beats that would complete a record. A WR_DATA beat always takes this rule, even if it is then classified as malformed.
- err_cnt saturates at all-ones and never wraps. It increments at most by 1 per cycle.
- clear has priority over every other update:
  - state goes to IDLE;
  - `req_vld` and `err_cnt` go to 0;
  - the beat presented in the clear cycle is accepted (`s_tready`=1) and discarded.

## Timing

- Reset values: state IDLE, `req_vld` 0, `req_typ`/`req_addr`/`req_data` 0, `req_strb` 0, `err_cnt` 0, `s_tready` 0 during reset.
- Latency: the record is valid on the cycle after the completing beat handshake.
- Throughput:
  - one read or read-return record per cycle when `req_rdy` is held at 1;
  - one write per two cycles.
- Simultaneous `req_rdy` handshake and completing beat: the old record is retired and the new one loaded in the same edge. `req_vld` stays 1.
- Record fields are stable while `req_vld=1` and `req_rdy=0`. No beat that would complete a record is accepted in that condition.
- Reset asserted mid-write: the partial write is lost and no record is emitted.

## Test plan

- Write: beat0 tuser=01, tdata=0x0000_3004, tlast=0; beat1 tuser=01, tdata=0xDEAD_BEEF, tstrb=4'h3, tlast=1 -> one cycle later `req_vld`=1, `req_typ`=01, `req_addr`=0x3004, `req_data`=0xDEADBEEF, `req_strb`=4'h3.
- Back-to-back reads: four tuser=10 beats with addr 0x10/0x14/0x18/0x1C, `req_rdy`=1 -> four consecutive records in order, no bubbles. Repeat with `req_rdy` low for 3 cycles -> `s_tready`=0 and record 0x10 held stable until `req_rdy` rises.
- Read-return: tuser=11, tdata=0x1234_5678, tlast=1 -> `req_typ`=11, `req_data`=0x12345678, `req_addr`=0.
- Malformed:
  - tuser=01 beat, then tuser=10 beat -> no record, `err_cnt`=1, state IDLE;
  - a following valid read -> record emitted normally;
  - tuser=00 beat -> `err_cnt`=2.
- Clear mid-write: accept write beat0, assert clear with beat1 presented -> no record, `err_cnt`=0, next read beat produces a correct record.
- Saturation: 300 tuser=00 beats -> `err_cnt`=255 and stays 255; `s_tready`=1 throughout.
